// File: rtl/jtdd_objdma.sv
// Copies the 2^OBJW-byte object table from main RAM to the object buffer once per vblank (JTDD_OBJDMA_DBLBUF_EN selects double-buffering).
// Latency: bus_req 1 cen after the LVBL fall; release 2^OBJW+1 cen after the grant when uninterrupted.
// Backpressure: a dropped bus_ack parks the copy; the unwritten address is re-read on regrant.
module jtdd_objdma #(
    parameter int OBJW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            LVBL,
    output logic            bus_req,
    input  logic            bus_ack,
    output logic            blcnten,
    output logic [OBJW-1:0] obj_AB,
    input  logic [7:0]      ram_dout,
    output logic [OBJW:0]   buf_addr,
    output logic [7:0]      buf_din,
    output logic            buf_we,
    output logic            buf_bank,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {IDLE, REQ, COPY, HOLD, FLUSH} state_t;

    state_t          st, st_nx;
    logic [OBJW:0]   addr, addr_nx, addr_m1;
    logic            first, first_nx;
    logic            lvbl_l;
    logic            wbank;
    logic            bus_req_nx, blcnten_nx, we_nx, done_nx, bank_nx, busy_nx;
    logic [OBJW:0]   waddr_nx;
    logic [7:0]      din_nx;

`ifdef JTDD_OBJDMA_DBLBUF_EN
    assign wbank = ~buf_bank;
`else
    assign wbank = 1'b0;
`endif

    assign addr_m1 = addr - (OBJW+1)'(1);
    // After the carry the address stays parked on the last entry instead of wrapping to 0
    assign obj_AB  = addr[OBJW] ? {OBJW{1'b1}} : addr[OBJW-1:0];

    always_comb begin
        st_nx      = st;
        addr_nx    = addr;
        first_nx   = first;
        bus_req_nx = bus_req;
        blcnten_nx = blcnten;
        we_nx      = buf_we;
        waddr_nx   = buf_addr;
        din_nx     = buf_din;
        done_nx    = 1'b0;
        bank_nx    = buf_bank;
        busy_nx    = busy;
        if (cen) begin
            we_nx = 1'b0;
            case (st)
                IDLE: if (lvbl_l && !LVBL) begin
                    st_nx      = REQ;
                    bus_req_nx = 1'b1;
                    busy_nx    = 1'b1;
                end
                REQ: if (bus_ack) begin
                    st_nx      = COPY;
                    blcnten_nx = 1'b1;
                    addr_nx    = '0;
                    first_nx   = 1'b1;
                end
                COPY: if (bus_ack) begin
                    if (!first) begin
                        we_nx    = 1'b1;
                        waddr_nx = {wbank, addr_m1[OBJW-1:0]};
                        din_nx   = ram_dout;
                    end
                    first_nx = 1'b0;
                    addr_nx  = addr + (OBJW+1)'(1);
                    if (addr == {1'b0, {OBJW{1'b1}}}) st_nx = FLUSH;
                end else begin
                    // The read in flight is lost: step back so it is fetched again
                    st_nx      = HOLD;
                    blcnten_nx = 1'b0;
                    first_nx   = 1'b1;
                    if (!first) addr_nx = addr_m1;
                end
                HOLD: if (bus_ack) begin
                    st_nx      = COPY;
                    blcnten_nx = 1'b1;
                end
                FLUSH: begin
                    we_nx      = 1'b1;
                    waddr_nx   = {wbank, addr_m1[OBJW-1:0]};
                    din_nx     = ram_dout;
                    bus_req_nx = 1'b0;
                    blcnten_nx = 1'b0;
                    done_nx    = 1'b1;
                    busy_nx    = 1'b0;
                    st_nx      = IDLE;
`ifdef JTDD_OBJDMA_DBLBUF_EN
                    bank_nx    = ~buf_bank;
`endif
                end
                default: st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            addr     <= '0;
            first    <= 1'b1;
            lvbl_l   <= 1'b0;
            bus_req  <= 1'b0;
            blcnten  <= 1'b0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_din  <= '0;
            done     <= 1'b0;
            buf_bank <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (cen) lvbl_l <= LVBL;
            st       <= st_nx;
            addr     <= addr_nx;
            first    <= first_nx;
            bus_req  <= bus_req_nx;
            blcnten  <= blcnten_nx;
            buf_we   <= we_nx;
            buf_addr <= waddr_nx;
            buf_din  <= din_nx;
            done     <= done_nx;
            buf_bank <= bank_nx;
            busy     <= busy_nx;
        end
    end

endmodule

// File: doc/jtdd_objdma.md
# jtdd_objdma

Object-table DMA engine for the Double Dragon core: on each vertical blank it requests the main CPU bus and copies the 512-byte object table from the top of main CPU work RAM into the object line-buffer RAM. It is the bus master on the other end of the main CPU's bus_req/bus_ack/blcnten/obj_AB interface, and it sits between the main CPU block and the object renderer.

## Interface
Parameters:
- OBJW, 9, object table address width; the table is 2^OBJW bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- cen  in  1  clock enable for the main RAM side (6 MHz); all state advances only on cen
- LVBL  in  1  vertical blank, active low
- bus_req  out  1  request for the main CPU bus
- bus_ack  in  1  bus granted by the main CPU
- blcnten  out  1  DMA owns the RAM address bus (selects obj_AB in the main block)
- obj_AB  out  OBJW  object table address presented to main RAM
- ram_dout  in  8  main RAM read data, valid one cen after the address is presented
- buf_addr  out  OBJW+1  object buffer write address; MSB is the bank bit
- buf_din  out  8  object buffer write data
- buf_we  out  1  object buffer write strobe, one cen wide
- buf_bank  out  1  bank currently owned by the renderer
- busy  out  1  high from trigger until release
- done  out  1  one-clock pulse on completion

## Operation
- Trigger: LVBL high-to-low edge, sampled on cen. The edge is ignored while busy.
- States:
  - IDLE: bus_req=0, blcnten=0. Trigger -> REQ.
  - REQ: bus_req=1. bus_ack=1 on cen -> COPY.
  - COPY: blcnten=1, obj_AB=addr. Each cen with bus_ack=1:
    - write the previous address: buf_we=1, buf_addr={wbank,addr-1}, buf_din=ram_dout (not on the first cycle);
    - then addr++.
    - After obj_AB=2^OBJW-1 has been presented -> FLUSH.
  - FLUSH: one cen writes the final byte, then bus_req=0, blcnten=0, done=1, toggle the bank -> IDLE.
- bus_ack drops in COPY:
  - blcnten=0 and buf_we=0 on the next cen; bus_req stays high.
  - The pending read is discarded.
  - When bus_ack returns, the engine re-presents the last unwritten address and the copy continues with no skipped or duplicated bytes.
- Address counter is OBJW+1 bits. Completion is detected on the carry, with no wrap into address 0.
- Reset values: bus_req=0, blcnten=0, obj_AB=0, buf_addr=0, buf_din=0, buf_we=0, buf_bank=0, busy=0, done=0, state IDLE.
- Reset mid-transfer: bus released on the same clock; the partial buffer is not banked.

## Timing
- Trigger cen to bus_req: 1 cen.
- bus_ack to the first obj_AB=0 with blcnten high: same cen transition into COPY.
- Uninterrupted transfer: 2^OBJW+1 cen from entering COPY to release (513 for OBJW=9).
- buf_we trails obj_AB by exactly 1 cen.
- done pulses in the clock where bus_req falls.
- busy falls in the same clock as done.

## Configuration
- JTDD_OBJDMA_DBLBUF_EN defined:
  - wbank = ~buf_bank and is the MSB of buf_addr;
  - buf_bank toggles at each completed transfer, so the renderer reads the bank just written.
- Not defined:
  - buf_addr MSB is always 0 and buf_bank is always 0;
  - the same buffer is rewritten every frame.

## Test plan
- Reset, then a single LVBL falling edge with bus_ack returned 2 cen after bus_req, RAM[n]=n^8'h5A -> buffer[n]=n^8'h5A for all 512 entries; release 513 cen after ack; one done pulse.
- bus_ack dropped for 10 cen when obj_AB=0x100 -> blcnten low during the gap; resume at 0x0FF/0x100; the buffer has no holes and no repeats.
- Second LVBL edge while busy -> ignored; exactly one transfer and one done.
- rst asserted in COPY at obj_AB=0x80 -> bus_req=0 and blcnten=0 on the next clock; buf_bank unchanged.
- JTDD_OBJDMA_DBLBUF_EN defined, two frames -> frame 1 written to bank 1, buf_bank=1; frame 2 written to bank 0, buf_bank=0.
